pic_interrupt_service: RTL and testbench
========================================

// Module: pic_interrupt_service
// PURPOSE
//  Request/service datapath of the 8259A PIC, downstream of the control logic. It synchronises IR0-IR7
//  and holds the IRR and ISR. It resolves priority under the rotation, mask and nesting rules, and
//  presents the winning request (one-hot) and the highest in-service level back to control.
//  IRR/ISR copies go to the read logic.
// PARAMETERS
//  SYNC_STAGES  2  IR pin synchroniser depth (>=2)
// PORTS
//  clk                       in   1  system clock; all state updates on falling edge
//  reset_n                   in   1  asynchronous active-low reset
//  interrupt_request_pin     in   8  raw IR7..IR0, asynchronous
//  ICW_1                     in   1  init pulse from control; clears IRR/ISR/edge state
//  LTIM                      in   1  1=level-triggered, 0=edge-triggered
//  interrupt_mask            in   8  IMR (1=masked)
//  EOI                       in   8  ISR bits to clear (one clock pulse)
//  freeze                    in   1  hold IRR and interrupt during INTA sequence
//  latch_in_service          in   1  set ISR bit of current interrupt
//  clear_interrupt_request   in   8  IRR bits to clear on acknowledge
//  priority_rotate           in   3  lowest-priority IR number (3'b111 -> IR0 highest)
//  interrupt                 out  8  one-hot winning request; 0 if none (registered)
//  highest_level_in_service  out  8  one-hot highest-priority ISR bit; 0 if none
//  interrupt_request_register out 8  IRR for read logic
//  in_service_register       out  8  ISR for read logic
// BEHAVIOUR
//  - Reset (reset_n=0, async): sync chain, IRR, ISR, interrupt all 0. ICW_1=1 does the same synchronously.
//  - Sync: IR sampled through SYNC_STAGES flops -> s; s_d = s delayed by one clock.
//  - IRR per bit, priority clear > freeze > set:
//    - clear_interrupt_request[i]: bit -> 0.
//    - freeze=1: bit held.
//    - Edge mode: set on s&~s_d. Held while s=1. Dropped if s=0 before ack.
//    - Level mode: IRR[i]=s[i].
//  - Latency: IR high first sampled at edge E0 -> IRR at E(SYNC_STAGES) -> interrupt at E(SYNC_STAGES+1).
//  - Priority: order starts at priority_rotate+1 (mod 8) and wraps. Both vectors are rotated right by
//    priority_rotate+1, the lowest set bit is picked, then the result is rotated back.
//  - Request winner: W = highest-priority bit of IRR&~interrupt_mask.
//  - highest_level_in_service: combinational highest-priority bit of ISR.
//  - interrupt register:
//    - freeze=1: held.
//    - Else W if W outranks highest_level_in_service (or ISR=0).
//    - Else 0 (fully nested: equal or lower never passes).
//  - ISR_next = (ISR & ~EOI) | (latch_in_service ? interrupt : 0). Same-bit EOI and latch: set wins.
//  - Mask change takes effect on the next falling edge. A masked bit remains in IRR.
//  - IR dropped in edge mode while freeze=1: IRR held until freeze falls, then cleared.
// CONFIGURATION
//  SPECIAL_MASK_MODE_EN defined:
//    - Adds input special_mask_mode (1 bit).
//    - When 1, the nesting compare uses ISR&~interrupt_mask, so masked in-service levels do not block
//      lower levels. highest_level_in_service is unchanged.
//  Not defined: no port; always fully nested.
// STRUCTURE
//  pic_pkg: NUM_IR=8; functions rotate_left/rotate_right(8b,3b), num2bit, bit2num,
//  resolve_priority (lowest-set-bit one-hot).
//  Sub-module pic_priority_resolver (combinational: vector + priority_rotate -> one-hot).
//  It is instantiated twice, for requests and for ISR.
// TESTING
//  - Reset mid-operation: IRR=8'h05, ISR=8'h01, reset_n=0 -> all outputs 0 immediately; post-reset IR0
//    still high and edge mode -> no new request until IR0 toggles low-high.
//  - Edge mode, IMR=00, rotate=7: IR3 rises at E0 -> IRR=08 at E2, interrupt=08 at E3. IR3 falls
//    before ack -> IRR=00, interrupt=00.
//  - Priority/rotate: IR1 and IR6 pending. rotate=7 -> interrupt=02. rotate=2 -> interrupt=40.
//    IMR=02, rotate=7 -> interrupt=40.
//  - Nesting: ISR=08 (IR3) with IR5 pending and rotate=7 -> interrupt=00. EOI=08 -> ISR=00, then
//    interrupt=20 on the next edge.
//  - Ack: interrupt=10 + latch_in_service -> ISR=10. freeze=1 with IR2 rising -> IRR unchanged.
//    clear_interrupt_request=10 -> IRR[4]=0.
//  - Level mode (LTIM=1): IR7 held high after clear -> IRR[7] re-asserts next edge.
//    SPECIAL_MASK_MODE_EN: ISR=01, IMR=01, IR4 -> interrupt=10.

Source files
------------

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259A-style interrupt service datapath.
//   NUM_IR            number of interrupt request lines
//   rotate_left/right circular rotate of an 8-bit vector by 0..7
//   num2bit/bit2num   IR number <-> one-hot conversion
//   resolve_priority  keep only the lowest set bit (bit 0 = highest priority)
// ---------------------------------------------------------------------------
package pic_pkg;

    localparam int NUM_IR = 8;

    function automatic logic [NUM_IR-1:0] rotate_right(input logic [NUM_IR-1:0] v,
                                                       input logic [2:0]        n);
        logic [2*NUM_IR-1:0] t;
        t = {v, v} >> n;
        return t[NUM_IR-1:0];
    endfunction

    function automatic logic [NUM_IR-1:0] rotate_left(input logic [NUM_IR-1:0] v,
                                                      input logic [2:0]        n);
        logic [2*NUM_IR-1:0] t;
        t = {v, v} << n;
        return t[2*NUM_IR-1:NUM_IR];
    endfunction

    function automatic logic [NUM_IR-1:0] num2bit(input logic [2:0] n);
        return NUM_IR'(1) << n;
    endfunction

    function automatic logic [2:0] bit2num(input logic [NUM_IR-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (v[i]) begin
                n = 3'(i);
            end
        end
        return n;
    endfunction

    // Two's-complement trick: v & -v isolates the lowest set bit.
    function automatic logic [NUM_IR-1:0] resolve_priority(input logic [NUM_IR-1:0] v);
        logic [NUM_IR-1:0] neg;
        neg = ~v + NUM_IR'(1);
        return v & neg;
    endfunction

endpackage

// File: rtl/pic_interrupt_service_if.sv
// ---------------------------------------------------------------------------
// pic_interrupt_service_if
// Bus between the PIC control logic (master) and the interrupt service
// datapath (slave).
//   Control -> service : ICW_1, LTIM, interrupt_mask, EOI, freeze,
//                        latch_in_service, clear_interrupt_request,
//                        priority_rotate
//   Service -> control : interrupt, highest_level_in_service,
//                        interrupt_request_register, in_service_register
// ---------------------------------------------------------------------------
interface pic_interrupt_service_if;
    import pic_pkg::*;

    logic              ICW_1;
    logic              LTIM;
    logic [NUM_IR-1:0] interrupt_mask;
    logic [NUM_IR-1:0] EOI;
    logic              freeze;
    logic              latch_in_service;
    logic [NUM_IR-1:0] clear_interrupt_request;
    logic [2:0]        priority_rotate;

    logic [NUM_IR-1:0] interrupt;
    logic [NUM_IR-1:0] highest_level_in_service;
    logic [NUM_IR-1:0] interrupt_request_register;
    logic [NUM_IR-1:0] in_service_register;

    modport master (
        output ICW_1, LTIM, interrupt_mask, EOI, freeze, latch_in_service,
               clear_interrupt_request, priority_rotate,
        input  interrupt, highest_level_in_service,
               interrupt_request_register, in_service_register
    );

    modport slave (
        input  ICW_1, LTIM, interrupt_mask, EOI, freeze, latch_in_service,
               clear_interrupt_request, priority_rotate,
        output interrupt, highest_level_in_service,
               interrupt_request_register, in_service_register
    );

endinterface

// File: rtl/pic_priority_resolver.sv
// ---------------------------------------------------------------------------
// pic_priority_resolver
// Combinational rotating-priority picker.
//   priority_rotate  in  3  lowest-priority IR number; priority_rotate+1 is highest
//   request          in  8  candidate vector
//   grant            out 8  one-hot highest-priority set bit of request, 0 if none
// ---------------------------------------------------------------------------
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [2:0]        priority_rotate,
    input  logic [NUM_IR-1:0] request,
    output logic [NUM_IR-1:0] grant
);

    logic [2:0]        shift;
    logic [NUM_IR-1:0] rotated;

    // Rotate so the highest-priority IR lands on bit 0, pick, rotate back.
    assign shift   = priority_rotate + 3'd1;
    assign rotated = rotate_right(request, shift);
    assign grant   = rotate_left(resolve_priority(rotated), shift);

endmodule

// File: rtl/pic_interrupt_service.sv
// ---------------------------------------------------------------------------
// pic_interrupt_service
// Request/service datapath of an 8259A PIC: synchronises IR0..IR7, keeps the
// IRR and ISR, resolves priority (rotation, mask, full nesting) and returns
// the winning request and the highest in-service level to the control logic.
// All state changes on the falling edge of clk.
//   clk                    in  system clock (falling-edge active)
//   reset_n                in  asynchronous active-low reset
//   interrupt_request_pin  in  raw IR7..IR0, asynchronous
//   special_mask_mode      in  only when SPECIAL_MASK_MODE_EN is defined
//   bus                    pic_interrupt_service_if.slave (control/status)
// Build option: SPECIAL_MASK_MODE_EN adds special_mask_mode; when it is 1,
// masked in-service levels stop blocking lower-priority requests.
// ---------------------------------------------------------------------------
module pic_interrupt_service
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IR-1:0] interrupt_request_pin,
`ifdef SPECIAL_MASK_MODE_EN
    input  logic              special_mask_mode,
`endif
    pic_interrupt_service_if.slave bus
);

    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    logic [NUM_IR-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IR-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IR-1:0] s_d_q, s_d_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [NUM_IR-1:0] irr_q, irr_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [NUM_IR-1:0] interrupt_q, interrupt_d;

    logic [NUM_IR-1:0] s;
    logic [NUM_IR-1:0] rising;
    logic              warm_done;
    logic [NUM_IR-1:0] winner;
    logic [NUM_IR-1:0] hlis;
    logic [NUM_IR-1:0] nest_level;
    logic [2:0]        shift;
    logic              outranks;

    assign s         = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == WARM_W'(SYNC_STAGES));
    // s_d is held at all-ones until the synchroniser has refilled after
    // reset/ICW1, so the zeros flushed out of the chain never look like a
    // low level: a line already high must go low and high again to request.
    assign rising    = s & ~s_d_q;
    assign shift     = bus.priority_rotate + 3'd1;

    pic_priority_resolver u_request_resolver (
        .priority_rotate (bus.priority_rotate),
        .request         (irr_q & ~bus.interrupt_mask),
        .grant           (winner)
    );

    pic_priority_resolver u_service_resolver (
        .priority_rotate (bus.priority_rotate),
        .request         (isr_q),
        .grant           (hlis)
    );

`ifdef SPECIAL_MASK_MODE_EN
    assign nest_level = special_mask_mode
                      ? rotate_left(resolve_priority(rotate_right(isr_q & ~bus.interrupt_mask, shift)), shift)
                      : hlis;
`else
    assign nest_level = hlis;
`endif

    // In the rotated frame a smaller bit index means higher priority;
    // equal level never passes (full nesting).
    assign outranks = (winner != '0) &&
                      ((nest_level == '0) ||
                       (bit2num(rotate_right(winner, shift)) < bit2num(rotate_right(nest_level, shift))));

    always_comb begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_d[k] = (k == 0) ? interrupt_request_pin : sync_q[(k == 0) ? 0 : k - 1];
        end
        s_d_d       = warm_done ? s : '1;
        warm_d      = warm_done ? warm_q : warm_q + WARM_W'(1);
        irr_d       = irr_q;
        isr_d       = (isr_q & ~bus.EOI) | (bus.latch_in_service ? interrupt_q : '0);
        interrupt_d = bus.freeze ? interrupt_q : (outranks ? winner : '0);

        for (int i = 0; i < NUM_IR; i++) begin
            if (bus.clear_interrupt_request[i]) begin
                irr_d[i] = 1'b0;
            end else if (bus.freeze) begin
                irr_d[i] = irr_q[i];
            end else if (bus.LTIM) begin
                irr_d[i] = s[i];
            end else begin
                irr_d[i] = (irr_q[i] & s[i]) | rising[i];
            end
        end

        if (bus.ICW_1) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_d[k] = '0;
            end
            s_d_d       = '1;
            warm_d      = '0;
            irr_d       = '0;
            isr_d       = '0;
            interrupt_d = '0;
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_d_q       <= '1;
            warm_q      <= '0;
            irr_q       <= '0;
            isr_q       <= '0;
            interrupt_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            s_d_q       <= s_d_d;
            warm_q      <= warm_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign bus.interrupt                  = interrupt_q;
    assign bus.highest_level_in_service   = hlis;
    assign bus.interrupt_request_register = irr_q;
    assign bus.in_service_register        = isr_q;

endmodule

// File: tb/tb_pic_interrupt_service.sv
// ---------------------------------------------------------------------------
// tb_pic_interrupt_service
// Directed stimulus against pic_interrupt_service with a rule-level model of
// the IRR/ISR/priority behaviour compared every rising clock edge, plus
// literal expectations at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_pic_interrupt_service;

    localparam int SYNC = 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] pins    = 8'h00;
    logic       checking = 1'b0;
`ifdef SPECIAL_MASK_MODE_EN
    logic       smm = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pic_interrupt_service_if bus();

    pic_interrupt_service #(.SYNC_STAGES(SYNC)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .interrupt_request_pin (pins),
`ifdef SPECIAL_MASK_MODE_EN
        .special_mask_mode     (smm),
`endif
        .bus                   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model helpers ----------------
    function automatic int rank_of(input int idx, input logic [2:0] rot);
        return (idx + 7 - int'(rot)) % 8;
    endfunction

    function automatic int idx_of(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] top_of(input logic [7:0] v, input logic [2:0] rot);
        logic [7:0] r;
        int best;
        r = 8'h00;
        best = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (best < 0 || rank_of(i, rot) < rank_of(best, rot))) best = i;
        if (best >= 0) r[best] = 1'b1;
        return r;
    endfunction

    function automatic bit beats(input logic [7:0] w, input logic [7:0] n, input logic [2:0] rot);
        if (w == 8'h00) return 1'b0;
        if (n == 8'h00) return 1'b1;
        return rank_of(idx_of(w), rot) < rank_of(idx_of(n), rot);
    endfunction

    function automatic logic [7:0] irr_next(input logic [7:0] irr, input logic [7:0] s,
                                            input logic [7:0] rise, input logic [7:0] clr,
                                            input logic frz, input logic ltim);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (clr[i])     r[i] = 1'b0;
            else if (frz)   r[i] = irr[i];
            else if (ltim)  r[i] = s[i];
            else            r[i] = (irr[i] & s[i]) | rise[i];
        end
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] m_hist [SYNC];   // pin samples, [0] newest
    int         m_age;           // edges since reset/ICW1, saturating
    logic [7:0] m_last_low;      // last valid synchronised level was low
    logic [7:0] m_irr, m_isr, m_int;
    logic [7:0] m_s, m_rise, m_w, m_nest, m_hl;

    assign m_s    = (m_age >= SYNC) ? m_hist[SYNC-1] : 8'h00;
    assign m_rise = (m_age >= SYNC) ? (m_s & m_last_low) : 8'h00;
    assign m_w    = top_of(m_irr & ~bus.interrupt_mask, bus.priority_rotate);
    assign m_hl   = top_of(m_isr, bus.priority_rotate);
`ifdef SPECIAL_MASK_MODE_EN
    assign m_nest = smm ? top_of(m_isr & ~bus.interrupt_mask, bus.priority_rotate) : m_hl;
`else
    assign m_nest = m_hl;
`endif

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n || bus.ICW_1) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] <= 8'h00;
            m_age      <= 0;
            m_last_low <= 8'h00;
            m_irr      <= 8'h00;
            m_isr      <= 8'h00;
            m_int      <= 8'h00;
        end else begin
            m_hist[0] <= pins;
            for (int k = 1; k < SYNC; k++) m_hist[k] <= m_hist[k-1];
            if (m_age < SYNC) m_age <= m_age + 1;
            if (m_age >= SYNC) m_last_low <= ~m_s;
            m_irr <= irr_next(m_irr, m_s, m_rise, bus.clear_interrupt_request, bus.freeze, bus.LTIM);
            m_isr <= (m_isr & ~bus.EOI) | (bus.latch_in_service ? m_int : 8'h00);
            m_int <= bus.freeze ? m_int
                   : (beats(m_w, m_nest, bus.priority_rotate) ? m_w : 8'h00);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (checking) begin
            check("cyc_interrupt", bus.interrupt, m_int);
            check("cyc_hlis", bus.highest_level_in_service, m_hl);
            check("cyc_irr", bus.interrupt_request_register, m_irr);
            check("cyc_isr", bus.in_service_register, m_isr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clean();
        pins      = 8'h00;
        bus.ICW_1 = 1'b1;
        cyc(1);
        bus.ICW_1 = 1'b0;
        cyc(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.ICW_1 = 1'b0;
        bus.LTIM = 1'b0;
        bus.interrupt_mask = 8'h00;
        bus.EOI = 8'h00;
        bus.freeze = 1'b0;
        bus.latch_in_service = 1'b0;
        bus.clear_interrupt_request = 8'h00;
        bus.priority_rotate = 3'd7;
        #2 reset_n = 1'b0;
        cyc(2);
        reset_n  = 1'b1;
        checking = 1'b1;
        check("rst_interrupt", bus.interrupt, 8'h00);
        check("rst_irr", bus.interrupt_request_register, 8'h00);
        check("rst_isr", bus.in_service_register, 8'h00);
        cyc(3);

        // edge mode, IR3 rise then fall before acknowledge
        pins = 8'h08;
        cyc(1);
        check("edge_irr_e0", bus.interrupt_request_register, 8'h00);
        cyc(1);
        check("edge_irr_e1", bus.interrupt_request_register, 8'h00);
        cyc(1);
        check("edge_irr_e2", bus.interrupt_request_register, 8'h08);
        check("edge_int_e2", bus.interrupt, 8'h00);
        cyc(1);
        check("edge_int_e3", bus.interrupt, 8'h08);
        $display("txn edge_ir3 irr=%02h int=%02h", bus.interrupt_request_register, bus.interrupt);
        pins = 8'h00;
        cyc(4);
        check("drop_irr", bus.interrupt_request_register, 8'h00);
        check("drop_int", bus.interrupt, 8'h00);

        // priority / rotation / mask
        pins = 8'h42;
        cyc(4);
        check("prio_rot7", bus.interrupt, 8'h02);
        bus.priority_rotate = 3'd2;
        cyc(1);
        check("prio_rot2", bus.interrupt, 8'h40);
        bus.priority_rotate = 3'd7;
        bus.interrupt_mask  = 8'h02;
        cyc(1);
        check("prio_mask", bus.interrupt, 8'h40);
        check("mask_irr_kept", bus.interrupt_request_register, 8'h42);
        $display("txn priority irr=%02h int=%02h", bus.interrupt_request_register, bus.interrupt);
        bus.interrupt_mask = 8'h00;

        // nesting: IR3 in service blocks IR5 until EOI
        clean();
        pins = 8'h08;
        cyc(4);
        check("nest_int3", bus.interrupt, 8'h08);
        bus.freeze = 1'b1;
        bus.latch_in_service = 1'b1;
        cyc(1);
        bus.latch_in_service = 1'b0;
        check("nest_isr", bus.in_service_register, 8'h08);
        bus.clear_interrupt_request = 8'h08;
        cyc(1);
        check("nest_clr", bus.interrupt_request_register, 8'h00);
        bus.clear_interrupt_request = 8'h00;
        bus.freeze = 1'b0;
        pins = 8'h28;
        cyc(5);
        check("nest_irr5", bus.interrupt_request_register, 8'h20);
        check("nest_blocked", bus.interrupt, 8'h00);
        check("nest_hlis", bus.highest_level_in_service, 8'h08);
        bus.EOI = 8'h08;
        cyc(1);
        bus.EOI = 8'h00;
        check("nest_eoi_isr", bus.in_service_register, 8'h00);
        cyc(1);
        check("nest_int5", bus.interrupt, 8'h20);
        $display("txn nesting isr=%02h int=%02h", bus.in_service_register, bus.interrupt);

        // acknowledge, freeze, clear
        clean();
        pins = 8'h10;
        cyc(4);
        check("ack_int4", bus.interrupt, 8'h10);
        bus.latch_in_service = 1'b1;
        cyc(1);
        bus.latch_in_service = 1'b0;
        check("ack_isr", bus.in_service_register, 8'h10);
        bus.freeze = 1'b1;
        pins = 8'h14;
        cyc(4);
        check("frz_irr", bus.interrupt_request_register, 8'h10);
        bus.clear_interrupt_request = 8'h10;
        cyc(1);
        check("ack_clr", bus.interrupt_request_register, 8'h00);
        bus.clear_interrupt_request = 8'h00;
        bus.freeze = 1'b0;
        bus.EOI = 8'h10;
        cyc(1);
        bus.EOI = 8'h00;
        $display("txn ack isr=%02h irr=%02h", bus.in_service_register, bus.interrupt_request_register);

        // asynchronous reset mid-operation
        clean();
        pins = 8'h05;
        cyc(4);
        bus.latch_in_service = 1'b1;
        cyc(1);
        bus.latch_in_service = 1'b0;
        check("pre_rst_irr", bus.interrupt_request_register, 8'h05);
        check("pre_rst_isr", bus.in_service_register, 8'h01);
        reset_n = 1'b0;
        #1;
        check("async_int", bus.interrupt, 8'h00);
        check("async_irr", bus.interrupt_request_register, 8'h00);
        check("async_isr", bus.in_service_register, 8'h00);
        check("async_hlis", bus.highest_level_in_service, 8'h00);
        cyc(2);
        reset_n = 1'b1;
        cyc(8);
        check("post_rst_irr", bus.interrupt_request_register, 8'h00);
        check("post_rst_int", bus.interrupt, 8'h00);
        pins = 8'h04;
        cyc(3);
        pins = 8'h05;
        cyc(4);
        check("retoggle_irr", bus.interrupt_request_register, 8'h01);
        check("retoggle_int", bus.interrupt, 8'h01);
        $display("txn reset irr=%02h int=%02h", bus.interrupt_request_register, bus.interrupt);

        // level mode
        clean();
        bus.LTIM = 1'b1;
        pins = 8'h80;
        cyc(3);
        check("lvl_irr", bus.interrupt_request_register, 8'h80);
        bus.clear_interrupt_request = 8'h80;
        cyc(1);
        check("lvl_clr", bus.interrupt_request_register, 8'h00);
        bus.clear_interrupt_request = 8'h00;
        cyc(1);
        check("lvl_reassert", bus.interrupt_request_register, 8'h80);
        pins = 8'h00;
        cyc(3);
        check("lvl_low", bus.interrupt_request_register, 8'h00);
        bus.LTIM = 1'b0;
        $display("txn level irr=%02h", bus.interrupt_request_register);

        // masked in-service level versus lower request
        clean();
        pins = 8'h01;
        cyc(4);
        bus.latch_in_service = 1'b1;
        cyc(1);
        bus.latch_in_service = 1'b0;
        check("smm_isr", bus.in_service_register, 8'h01);
        bus.interrupt_mask = 8'h01;
`ifdef SPECIAL_MASK_MODE_EN
        smm = 1'b1;
`endif
        pins = 8'h11;
        cyc(5);
`ifdef SPECIAL_MASK_MODE_EN
        check("smm_int", bus.interrupt, 8'h10);
`else
        check("nested_int", bus.interrupt, 8'h00);
`endif
        $display("txn masked_isr int=%02h", bus.interrupt);
        bus.interrupt_mask = 8'h00;
        cyc(2);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
